// File: rtl/decode_stage_pipe_if.sv
// Bus bundle for the decode stage.
//   master : upstream/hazard side; drives the fetch, forwarding, writeback and
//            hazard inputs and receives the redirect and ID/EX outputs.
//   slave  : the decode stage itself.
// Signals:
//   instr_D, pcplus4_D, ctrl_D, branch_D, branch_type_D, jump_D  decode inputs
//   forwardA_D, forwardB_D, alu_out_M                            compare forwarding
//   a3_W, wd3_W, reg_write_W                                     register-file write
//   stall_E, flush_E                                             ID/EX hold and bubble
//   pc_src_D, pc_branch_D, pc_jump_D                             next-PC selection
//   rd1_E .. valid_E                                             ID/EX register contents
interface decode_stage_pipe_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CTRL_W     = 8
);
   logic [31:0]           instr_D;
   logic [DATA_W-1:0]     pcplus4_D;
   logic [CTRL_W-1:0]     ctrl_D;
   logic                  branch_D;
   logic [1:0]            branch_type_D;
   logic                  jump_D;
   logic [1:0]            forwardA_D;
   logic [1:0]            forwardB_D;
   logic [DATA_W-1:0]     alu_out_M;
   logic [REG_ADDR_W-1:0] a3_W;
   logic [DATA_W-1:0]     wd3_W;
   logic                  reg_write_W;
   logic                  stall_E;
   logic                  flush_E;

   logic [1:0]            pc_src_D;
   logic [DATA_W-1:0]     pc_branch_D;
   logic [DATA_W-1:0]     pc_jump_D;
   logic [DATA_W-1:0]     rd1_E;
   logic [DATA_W-1:0]     rd2_E;
   logic [DATA_W-1:0]     imm_E;
   logic [REG_ADDR_W-1:0] rs_E;
   logic [REG_ADDR_W-1:0] rt_E;
   logic [REG_ADDR_W-1:0] rd_E;
   logic [CTRL_W-1:0]     ctrl_E;
   logic                  valid_E;

   modport master (
      output instr_D, pcplus4_D, ctrl_D, branch_D, branch_type_D, jump_D,
      output forwardA_D, forwardB_D, alu_out_M, a3_W, wd3_W, reg_write_W,
      output stall_E, flush_E,
      input  pc_src_D, pc_branch_D, pc_jump_D,
      input  rd1_E, rd2_E, imm_E, rs_E, rt_E, rd_E, ctrl_E, valid_E
   );

   modport slave (
      input  instr_D, pcplus4_D, ctrl_D, branch_D, branch_type_D, jump_D,
      input  forwardA_D, forwardB_D, alu_out_M, a3_W, wd3_W, reg_write_W,
      input  stall_E, flush_E,
      output pc_src_D, pc_branch_D, pc_jump_D,
      output rd1_E, rd2_E, imm_E, rs_E, rt_E, rd_E, ctrl_E, valid_E
   );
endinterface

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: register file with write-through reads, immediate sign
// extension, branch/jump target generation, early branch resolution with M/W
// forwarding, and the ID/EX pipeline register with stall and flush.
// Ports:
//   clk   rising-edge clock
//   reset asynchronous active-high reset; clears register file and ID/EX
//   bus   decode_stage_pipe_if.slave carrying all data/control signals
module decode_stage_pipe #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CTRL_W     = 8
) (
   input logic                clk,
   input logic                reset,
   decode_stage_pipe_if.slave bus
);
   localparam int unsigned NumRegs = 1 << REG_ADDR_W;

   if (DATA_W < 32) begin : gen_width_check
      $error("decode_stage_pipe: DATA_W must be at least 32");
   end

   // ---------------------------------------------------------------------------
   // Instruction fields
   // ---------------------------------------------------------------------------
   logic [REG_ADDR_W-1:0] rs_a;
   logic [REG_ADDR_W-1:0] rt_a;
   logic [REG_ADDR_W-1:0] rd_a;
   logic [DATA_W-1:0]     imm;
   logic                  unused_opcode;

   // Casts zero-extend or truncate the 5-bit fields to the register address width.
   assign rs_a = REG_ADDR_W'(bus.instr_D[25:21]);
   assign rt_a = REG_ADDR_W'(bus.instr_D[20:16]);
   assign rd_a = REG_ADDR_W'(bus.instr_D[15:11]);
   assign imm  = {{(DATA_W-16){bus.instr_D[15]}}, bus.instr_D[15:0]};

   assign unused_opcode = ^bus.instr_D[31:26];

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   logic [NumRegs-1:0][DATA_W-1:0] regs_q;
   logic                           wr_en;
   logic [DATA_W-1:0]              rd1;
   logic [DATA_W-1:0]              rd2;

   assign wr_en = bus.reg_write_W && (bus.a3_W != '0);

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '0;
      end else if (wr_en) begin
         regs_q[bus.a3_W] <= bus.wd3_W;
      end
   end

   // Write-through: a same-cycle writeback to the read address is visible now.
   always_comb begin
      rd1 = regs_q[rs_a];
      if (rs_a == '0) begin
         rd1 = '0;
      end else if (wr_en && (bus.a3_W == rs_a)) begin
         rd1 = bus.wd3_W;
      end
   end

   always_comb begin
      rd2 = regs_q[rt_a];
      if (rt_a == '0) begin
         rd2 = '0;
      end else if (wr_en && (bus.a3_W == rt_a)) begin
         rd2 = bus.wd3_W;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-PC targets
   // ---------------------------------------------------------------------------
   assign bus.pc_branch_D = bus.pcplus4_D + (imm << 2);
   assign bus.pc_jump_D   = {bus.pcplus4_D[DATA_W-1:28], bus.instr_D[25:0], 2'b00};

   // ---------------------------------------------------------------------------
   // Early branch resolution
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              cmp;
   logic              branch_taken;

   always_comb begin
      case (bus.forwardA_D)
         2'b01:   op_a = bus.alu_out_M;
         2'b10:   op_a = bus.wd3_W;
         default: op_a = rd1;
      endcase
   end

   always_comb begin
      case (bus.forwardB_D)
         2'b01:   op_b = bus.alu_out_M;
         2'b10:   op_b = bus.wd3_W;
         default: op_b = rd2;
      endcase
   end

   // blez/bgtz test the sign bit and zero-ness of A only.
   always_comb begin
      case (bus.branch_type_D)
         2'b00:   cmp = (op_a == op_b);
         2'b01:   cmp = (op_a != op_b);
         2'b10:   cmp = op_a[DATA_W-1] || (op_a == '0);
         default: cmp = !op_a[DATA_W-1] && (op_a != '0);
      endcase
   end

   assign branch_taken = bus.branch_D && cmp;

   // Both set gives 2'b11; the fetch mux resolves that as a jump.
   assign bus.pc_src_D = {bus.jump_D, branch_taken};

   // ---------------------------------------------------------------------------
   // ID/EX pipeline register: reset > flush > stall > load
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0]     rd1_q;
   logic [DATA_W-1:0]     rd2_q;
   logic [DATA_W-1:0]     imm_q;
   logic [REG_ADDR_W-1:0] rs_q;
   logic [REG_ADDR_W-1:0] rt_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [CTRL_W-1:0]     ctrl_q;
   logic                  valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
      end else if (bus.flush_E) begin
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
      end else if (!bus.stall_E) begin
         // Raw register-file values; forwarding into EX is handled downstream.
         rd1_q   <= rd1;
         rd2_q   <= rd2;
         imm_q   <= imm;
         rs_q    <= rs_a;
         rt_q    <= rt_a;
         rd_q    <= rd_a;
         ctrl_q  <= bus.ctrl_D;
         valid_q <= 1'b1;
      end
   end

   assign bus.rd1_E   = rd1_q;
   assign bus.rd2_E   = rd2_q;
   assign bus.imm_E   = imm_q;
   assign bus.rs_E    = rs_q;
   assign bus.rt_E    = rt_q;
   assign bus.rd_E    = rd_q;
   assign bus.ctrl_E  = ctrl_q;
   assign bus.valid_E = valid_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned CTRL_W     = 8;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        br;
      logic [1:0]  bt;
      logic        jmp;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] alu;
      logic [1:0]  exp_src;
      int          kind;     // 0 none, 1 check branch target, 2 check jump target
      logic [31:0] exp_tgt;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   decode_stage_pipe_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W)) bus ();

   decode_stage_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] model_regs [32];
   logic [31:0] e_rd1, e_rd2, e_imm;
   logic [4:0]  e_rs, e_rt, e_rd;
   logic [7:0]  e_ctrl;
   logic        e_valid;

   vec_t vecs [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic idle();
      bus.instr_D       = '0;
      bus.pcplus4_D     = '0;
      bus.ctrl_D        = '0;
      bus.branch_D      = 1'b0;
      bus.branch_type_D = 2'b00;
      bus.jump_D        = 1'b0;
      bus.forwardA_D    = 2'b00;
      bus.forwardB_D    = 2'b00;
      bus.alu_out_M     = '0;
      bus.a3_W          = '0;
      bus.wd3_W         = '0;
      bus.reg_write_W   = 1'b0;
      bus.stall_E       = 1'b0;
      bus.flush_E       = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      e_rd1 = '0; e_rd2 = '0; e_imm = '0;
      e_rs = '0; e_rt = '0; e_rd = '0;
      e_ctrl = '0; e_valid = 1'b0;
   endtask

   function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
      return {6'd4, rs, rt, imm};
   endfunction

   function automatic vec_t mk(input string name, input logic [31:0] instr,
                               input logic [31:0] pc, input logic br, input logic [1:0] bt,
                               input logic jmp, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] alu, input logic [1:0] src, input int kind,
                               input logic [31:0] tgt);
      vec_t v;
      v.name = name; v.instr = instr; v.pc = pc; v.br = br; v.bt = bt; v.jmp = jmp;
      v.fa = fa; v.fb = fb; v.alu = alu; v.exp_src = src; v.kind = kind; v.exp_tgt = tgt;
      return v;
   endfunction

   // Architectural register read as seen in decode this cycle.
   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (bus.reg_write_W && bus.a3_W == a) return bus.wd3_W;
      return model_regs[a];
   endfunction

   function automatic logic [31:0] operand(input logic [1:0] sel, input logic [4:0] a);
      if (sel == 2'b01) return bus.alu_out_M;
      if (sel == 2'b10) return bus.wd3_W;
      return model_read(a);
   endfunction

   function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] bt);
      case (bt)
         2'd0:    return a == b;
         2'd1:    return a != b;
         2'd2:    return $signed(a) <= 0;
         default: return $signed(a) > 0;
      endcase
   endfunction

   task automatic check_comb(input string tag);
      logic [31:0] a, b, tgt_b, tgt_j;
      logic        taken;
      a      = operand(bus.forwardA_D, bus.instr_D[25:21]);
      b      = operand(bus.forwardB_D, bus.instr_D[20:16]);
      taken  = bus.branch_D && ref_taken(a, b, bus.branch_type_D);
      tgt_b  = bus.pcplus4_D + 32'(4 * int'($signed(bus.instr_D[15:0])));
      tgt_j  = (bus.pcplus4_D & 32'hF000_0000) | ({6'd0, bus.instr_D[25:0]} << 2);
      check({tag, ".pc_src"}, bus.pc_src_D, {bus.jump_D, taken});
      check({tag, ".pc_branch"}, bus.pc_branch_D, tgt_b);
      check({tag, ".pc_jump"}, bus.pc_jump_D, tgt_j);
   endtask

   task automatic check_e(input string tag);
      check({tag, ".rd1_E"}, bus.rd1_E, e_rd1);
      check({tag, ".rd2_E"}, bus.rd2_E, e_rd2);
      check({tag, ".imm_E"}, bus.imm_E, e_imm);
      check({tag, ".rs_E"}, bus.rs_E, e_rs);
      check({tag, ".rt_E"}, bus.rt_E, e_rt);
      check({tag, ".rd_E"}, bus.rd_E, e_rd);
      check({tag, ".ctrl_E"}, bus.ctrl_E, e_ctrl);
      check({tag, ".valid_E"}, bus.valid_E, e_valid);
   endtask

   // Predict the ID/EX contents and register file after the coming edge, then
   // advance to 1 time unit past that edge.
   task automatic tick();
      if (bus.flush_E) begin
         e_rd1 = '0; e_rd2 = '0; e_imm = '0;
         e_rs = '0; e_rt = '0; e_rd = '0;
         e_ctrl = '0; e_valid = 1'b0;
      end else if (!bus.stall_E) begin
         e_rd1   = model_read(bus.instr_D[25:21]);
         e_rd2   = model_read(bus.instr_D[20:16]);
         e_imm   = 32'(int'($signed(bus.instr_D[15:0])));
         e_rs    = bus.instr_D[25:21];
         e_rt    = bus.instr_D[20:16];
         e_rd    = bus.instr_D[15:11];
         e_ctrl  = bus.ctrl_D;
         e_valid = 1'b1;
      end
      if (bus.reg_write_W && bus.a3_W != 0) model_regs[bus.a3_W] = bus.wd3_W;
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      idle();
      bus.reg_write_W = 1'b1;
      bus.a3_W        = a;
      bus.wd3_W       = d;
      tick();
   endtask

   initial begin
      vecs[0]  = mk("beq_taken",   ins(8, 9, 16'hFFFE), 32'h100, 1, 2'd0, 0, 2'd0, 2'd0, 0,
                    2'b01, 1, 32'h0F8);
      vecs[1]  = mk("beq_fwd11",   ins(8, 9, 16'h0004), 32'h200, 1, 2'd0, 0, 2'd3, 2'd3, 0,
                    2'b01, 1, 32'h210);
      vecs[2]  = mk("beq_ne",      ins(8, 3, 16'h0000), 32'h0,   1, 2'd0, 0, 2'd0, 2'd0, 0,
                    2'b00, 1, 32'h0);
      vecs[3]  = mk("bne_fwdA",    ins(3, 3, 16'h0010), 32'h1000, 1, 2'd1, 0, 2'd1, 2'd0, 9,
                    2'b01, 1, 32'h1040);
      vecs[4]  = mk("bne_eq",      ins(3, 3, 16'h0000), 32'h0,   1, 2'd1, 0, 2'd0, 2'd0, 0,
                    2'b00, 0, 32'h0);
      vecs[5]  = mk("blez_neg",    ins(3, 0, 16'h0000), 32'h0,   1, 2'd2, 0, 2'd1, 2'd0,
                    32'h8000_0000, 2'b01, 0, 32'h0);
      vecs[6]  = mk("blez_zero",   ins(0, 0, 16'h0000), 32'h0,   1, 2'd2, 0, 2'd0, 2'd0, 0,
                    2'b01, 0, 32'h0);
      vecs[7]  = mk("blez_pos",    ins(3, 0, 16'h0000), 32'h0,   1, 2'd2, 0, 2'd0, 2'd0, 0,
                    2'b00, 0, 32'h0);
      vecs[8]  = mk("bgtz_zero",   ins(0, 0, 16'h0000), 32'h0,   1, 2'd3, 0, 2'd0, 2'd0, 0,
                    2'b00, 0, 32'h0);
      vecs[9]  = mk("bgtz_pos",    ins(3, 0, 16'h0000), 32'h0,   1, 2'd3, 0, 2'd0, 2'd0, 0,
                    2'b01, 0, 32'h0);
      vecs[10] = mk("bgtz_neg",    ins(3, 0, 16'h0000), 32'h0,   1, 2'd3, 0, 2'd1, 2'd0,
                    32'hFFFF_FFFF, 2'b00, 0, 32'h0);
      vecs[11] = mk("jump",        32'h0800_0010, 32'hA000_0004, 0, 2'd0, 1, 2'd0, 2'd0, 0,
                    2'b10, 2, 32'hA000_0040);
      vecs[12] = mk("jump_branch", ins(8, 9, 16'h0000), 32'h0,   1, 2'd0, 1, 2'd0, 2'd0, 0,
                    2'b11, 0, 32'h0);
      vecs[13] = mk("no_branch",   ins(8, 9, 16'h0000), 32'h0,   0, 2'd0, 0, 2'd0, 2'd0, 0,
                    2'b00, 0, 32'h0);
      vecs[14] = mk("beq_fwdB",    ins(8, 3, 16'h0000), 32'h0,   1, 2'd0, 0, 2'd0, 2'd1, 7,
                    2'b01, 0, 32'h0);
      vecs[15] = mk("br_wrap",     ins(8, 9, 16'h0001), 32'hFFFF_FFFC, 1, 2'd0, 0, 2'd0, 2'd0,
                    0, 2'b01, 1, 32'h0);
      vecs[16] = mk("br_maxpos",   ins(8, 9, 16'h7FFF), 32'h0,   1, 2'd0, 0, 2'd0, 2'd0, 0,
                    2'b01, 1, 32'h0001_FFFC);
      vecs[17] = mk("blez_fwdW",   ins(3, 0, 16'h0000), 32'h0,   1, 2'd2, 0, 2'd2, 2'd0, 0,
                    2'b01, 0, 32'h0);

      // Reset state
      clear_model();
      idle();
      reset = 1'b1;
      #1;
      check_e("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Write-through: r8 written while decode reads rs=8
      idle();
      bus.instr_D     = ins(8, 0, 16'h0000);
      bus.reg_write_W = 1'b1;
      bus.a3_W        = 5'd8;
      bus.wd3_W       = 32'h0000_0005;
      tick();
      check("wt.rd1_E", bus.rd1_E, 32'h5);
      check_e("wt");

      // r0 write is discarded, including the same-cycle bypass
      idle();
      bus.reg_write_W = 1'b1;
      bus.a3_W        = 5'd0;
      bus.wd3_W       = 32'hFFFF_FFFF;
      tick();
      check("r0_bypass.rd1_E", bus.rd1_E, 32'h0);
      idle();
      tick();
      check("r0_later.rd1_E", bus.rd1_E, 32'h0);
      check("r0_later.rd2_E", bus.rd2_E, 32'h0);

      write_reg(5'd8, 32'd7);
      write_reg(5'd9, 32'd7);
      write_reg(5'd3, 32'd3);

      // Table-driven branch/jump vectors
      for (int i = 0; i < 18; i++) begin
         idle();
         bus.instr_D       = vecs[i].instr;
         bus.pcplus4_D     = vecs[i].pc;
         bus.branch_D      = vecs[i].br;
         bus.branch_type_D = vecs[i].bt;
         bus.jump_D        = vecs[i].jmp;
         bus.forwardA_D    = vecs[i].fa;
         bus.forwardB_D    = vecs[i].fb;
         bus.alu_out_M     = vecs[i].alu;
         bus.ctrl_D        = 8'(i + 1);
         #1;
         check({vecs[i].name, ".src"}, bus.pc_src_D, vecs[i].exp_src);
         if (vecs[i].kind == 1) check({vecs[i].name, ".br_tgt"}, bus.pc_branch_D, vecs[i].exp_tgt);
         if (vecs[i].kind == 2) check({vecs[i].name, ".j_tgt"}, bus.pc_jump_D, vecs[i].exp_tgt);
         check_comb(vecs[i].name);
         tick();
         check_e(vecs[i].name);
      end

      // Stall holds for 3 cycles, then stall+flush gives a bubble
      idle();
      bus.instr_D = {6'd4, 5'd8, 5'd9, 16'h9234};
      bus.ctrl_D  = 8'hA5;
      tick();
      check("load.rd1_E", bus.rd1_E, 32'd7);
      check("load.imm_E", bus.imm_E, 32'hFFFF_9234);
      check_e("load");
      bus.instr_D = ins(3, 3, 16'h1111);
      bus.ctrl_D  = 8'h5A;
      bus.stall_E = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("stall.ctrl_E", bus.ctrl_E, 8'hA5);
         check("stall.rd2_E", bus.rd2_E, 32'd7);
         check_e("stall");
      end
      bus.flush_E = 1'b1;
      tick();
      check("flush.valid_E", bus.valid_E, 1'b0);
      check("flush.ctrl_E", bus.ctrl_E, 8'h00);
      check_e("flush");
      bus.flush_E = 1'b0;
      bus.stall_E = 1'b0;
      tick();
      check("resume.valid_E", bus.valid_E, 1'b1);
      check_e("resume");

      // Asynchronous reset mid-run, between clock edges
      #2;
      reset = 1'b1;
      #1;
      check("async_rst.rd1_E", bus.rd1_E, 32'h0);
      check("async_rst.valid_E", bus.valid_E, 1'b0);
      check("async_rst.ctrl_E", bus.ctrl_E, 8'h00);
      clear_model();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int r = 1; r < 32; r++) begin
         idle();
         bus.instr_D = ins(5'(r), 5'(r), 16'h0000);
         tick();
         check("post_rst.rd1_E", bus.rd1_E, 32'h0);
         check("post_rst.rd2_E", bus.rd2_E, 32'h0);
      end

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         bus.instr_D       = $urandom;
         bus.pcplus4_D     = $urandom;
         bus.ctrl_D        = 8'($urandom);
         bus.branch_D      = 1'($urandom);
         bus.branch_type_D = 2'($urandom);
         bus.jump_D        = ($urandom_range(0, 7) == 0);
         bus.forwardA_D    = 2'($urandom);
         bus.forwardB_D    = 2'($urandom);
         bus.alu_out_M     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1
                                                         : $urandom;
         bus.reg_write_W   = ($urandom_range(0, 2) != 0);
         bus.a3_W          = 5'($urandom);
         bus.wd3_W         = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         bus.stall_E       = ($urandom_range(0, 5) == 0);
         bus.flush_E       = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) begin
            bus.forwardA_D = 2'b01;
            bus.alu_out_M  = model_read(bus.instr_D[20:16]);
         end
         #1;
         check_comb("rand");
         tick();
         check_e("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised next-generation MIPS decode stage. Contains the register file, immediate extension, branch and jump target generation, and early branch resolution.
- Resolves beq/bne/blez/bgtz, with forwarding from the M and W stages.
- Contains the ID/EX pipeline register, with stall (hold) and flush (bubble) control.
- Sits between fetch (IF/ID register) and the execute stage.

Parameters:
- DATA_W, 32: datapath width. Must be >= 32.
- REG_ADDR_W, 5: register address width. Register count = 2**REG_ADDR_W.
- CTRL_W, 8: width of the opaque control bundle carried from ID to EX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_D  in  32  decode-stage instruction. Fields: rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], target=[25:0]. Address fields are zero-extended or truncated to REG_ADDR_W.
- pcplus4_D  in  DATA_W  PC+4 of the instruction in decode.
- ctrl_D  in  CTRL_W  control bundle from the main decoder.
- branch_D  in  1  instruction is a conditional branch.
- branch_type_D  in  2  00 beq, 01 bne, 10 blez, 11 bgtz.
- jump_D  in  1  instruction is j.
- forwardA_D  in  2  compare operand A select: 00 register file, 01 alu_out_M, 10 wd3_W, 11 register file.
- forwardB_D  in  2  same encoding as forwardA_D, for operand B.
- alu_out_M  in  DATA_W  memory-stage ALU result.
- a3_W  in  REG_ADDR_W  writeback destination.
- wd3_W  in  DATA_W  writeback data.
- reg_write_W  in  1  writeback enable.
- stall_E  in  1  hold the ID/EX register.
- flush_E  in  1  load a bubble into the ID/EX register.
- pc_src_D  out  2  {jump_D, branch_taken}; combinational.
- pc_branch_D  out  DATA_W  branch target; combinational.
- pc_jump_D  out  DATA_W  jump target; combinational.
- rd1_E  out  DATA_W  registered operand 1 (register-file value).
- rd2_E  out  DATA_W  registered operand 2 (register-file value).
- imm_E  out  DATA_W  registered sign-extended immediate.
- rs_E  out  REG_ADDR_W  registered rs.
- rt_E  out  REG_ADDR_W  registered rt.
- rd_E  out  REG_ADDR_W  registered rd.
- ctrl_E  out  CTRL_W  registered control bundle.
- valid_E  out  1  registered; 0 marks a bubble.

Behaviour:
- Register file:
  - 2**REG_ADDR_W entries of DATA_W bits, all cleared asynchronously on reset.
  - Write on rising clk when reg_write_W=1 and a3_W!=0. Register 0 always reads 0 and is never written.
  - Reads are combinational and write-through: if reg_write_W=1, a3_W!=0 and a3_W equals the read address, the read returns wd3_W in the same cycle.
- Immediate: imm = sign-extension of instr_D[15:0] to DATA_W.
- Branch target: pc_branch_D = pcplus4_D + (imm << 2), modulo 2**DATA_W, no overflow flag.
- Jump target: pc_jump_D = {pcplus4_D[DATA_W-1:28], instr_D[25:0], 2'b00}.
- Branch comparison, on operands A and B selected by forwardA_D / forwardB_D:
  - beq: A==B.
  - bne: A!=B.
  - blez: signed A <= 0.
  - bgtz: signed A > 0.
  - blez and bgtz ignore B.
- branch_taken = branch_D AND compare result.
- pc_src_D = {jump_D, branch_taken}. jump_D and branch_D both 1 yields 2'b11; the fetch mux treats this as jump.
- ID/EX register, one-cycle latency, priority reset > flush_E > stall_E > load:
  - reset (async): all outputs 0, valid_E=0.
  - flush_E=1: ctrl_E=0, valid_E=0, all other fields 0. Flush wins when stall_E=1 in the same cycle.
  - stall_E=1 (flush_E=0): all E outputs hold their values.
  - Otherwise, load:
    - rd1_E, rd2_E = register-file read values (not the forwarded compare operands).
    - imm_E = imm.
    - rs_E, rt_E, rd_E = instruction fields.
    - ctrl_E = ctrl_D, valid_E=1.
- Reset asserted mid-operation clears the register file and ID/EX immediately, without waiting for clk. Combinational outputs keep following their inputs.
- A write to register 0 is discarded. A read of register 0 through the W-stage bypass still returns 0.

Test Plan:
- Assert reset mid-run with registers loaded -> rd1_E=0, valid_E=0 and ctrl_E=0 immediately, before any clk edge. Reads of r1..r31 return 0 after release.
- Write r8=32'h0000_0005 via W while decode reads rs=8 in the same cycle -> rd1_E=5 after the next edge (write-through). A write of 32'hFFFF_FFFF to r0 -> later reads of r0 return 0.
- beq with r8=r9=7, forward=00 -> pc_src_D=2'b01, pc_branch_D = pcplus4_D + 4*imm. With imm=16'hFFFE and pcplus4_D=32'h100 -> 32'h0F8.
- bne with regfile A=3, forwardA_D=01, alu_out_M=9, B=3 -> taken. blez with A=32'h8000_0000 -> taken. bgtz with A=0 -> not taken.
- jump_D=1, pcplus4_D=32'hA000_0004, target=26'h0000_010 -> pc_jump_D=32'hA000_0040, pc_src_D[1]=1.
- Load ID/EX, then hold stall_E=1 for 3 cycles -> outputs unchanged. Then assert stall_E and flush_E together -> valid_E=0, ctrl_E=0. Next normal cycle -> valid_E=1.
